// File: rtl/inst_mem_resp_if.sv
// Fetch and loader signal bundle between the IF stage / program loader and
// the instruction memory responder.
interface inst_mem_resp_if #(
  parameter int DEPTH_LOG2 = 10
) ();
  logic                  ice;
  logic [31:0]           iaddr;
  logic                  flush;
  logic                  ld_we;
  logic [DEPTH_LOG2-1:0] ld_addr;
  logic [31:0]           ld_data;
  logic [31:0]           inst;
  logic                  inst_valid;
  logic                  stall_req;
  logic                  adel;

  modport master (
    output ice, iaddr, flush, ld_we, ld_addr, ld_data,
    input  inst, inst_valid, stall_req, adel
  );

  modport slave (
    input  ice, iaddr, flush, ld_we, ld_addr, ld_data,
    output inst, inst_valid, stall_req, adel
  );
endinterface

// File: rtl/inst_mem_resp.sv
// Instruction memory with a programmable fetch latency, loader write port,
// flush cancellation and misaligned-fetch error reporting.
module inst_mem_resp #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic            cpu_clk_50M,
  input  logic            cpu_rst,
  inst_mem_resp_if.slave  bus
);

  localparam int         DEPTH  = 1 << DEPTH_LOG2;
  localparam logic [2:0] WAIT_C = 3'(WAIT_CYCLES);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t                state_r;
  logic [2:0]            cnt_r;
  logic [31:0]           inst_r;
  logic                  inst_valid_r;
  logic                  adel_r;
  logic [DEPTH_LOG2-1:0] idx_r;
  logic                  mis_r;
  logic [31:0]           mem_r [DEPTH];

  logic [DEPTH_LOG2-1:0] idx_s;
  logic                  mis_s;
  logic [31-DEPTH_LOG2-2:0] iaddr_hi_unused_s;

  // Decode the fetch address into a word index and a misalignment flag.
  always_comb begin
    idx_s             = bus.iaddr[DEPTH_LOG2+1:2];
    mis_s             = (bus.iaddr[1:0] != 2'b00);
    iaddr_hi_unused_s = bus.iaddr[31:DEPTH_LOG2+2];
  end

  // Loader write port; the array itself is never cleared by reset.
  always_ff @(posedge cpu_clk_50M) begin
    if (bus.ld_we && !cpu_rst) begin
      mem_r[bus.ld_addr] <= bus.ld_data;
    end
  end

  // Fetch FSM with registered response outputs; reading the array at the
  // completion edge makes writes landing during the wait visible.
  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      state_r      <= IDLE;
      cnt_r        <= 3'd0;
      inst_r       <= 32'h0;
      inst_valid_r <= 1'b0;
      adel_r       <= 1'b0;
      idx_r        <= '0;
      mis_r        <= 1'b0;
    end else begin
      inst_valid_r <= 1'b0;
      adel_r       <= 1'b0;
      if (bus.flush) begin
        state_r <= IDLE;
        cnt_r   <= 3'd0;
      end else begin
        case (state_r)
          IDLE: begin
            if (bus.ice) begin
              if (WAIT_CYCLES == 0) begin
                inst_r       <= mis_s ? 32'h0 : mem_r[idx_s];
                inst_valid_r <= 1'b1;
                adel_r       <= mis_s;
              end else begin
                state_r <= BUSY;
                cnt_r   <= WAIT_C;
                idx_r   <= idx_s;
                mis_r   <= mis_s;
              end
            end
          end
          BUSY: begin
            if (cnt_r == 3'd1) begin
              inst_r       <= mis_r ? 32'h0 : mem_r[idx_r];
              inst_valid_r <= 1'b1;
              adel_r       <= mis_r;
              state_r      <= IDLE;
              cnt_r        <= 3'd0;
            end else begin
              cnt_r <= cnt_r - 3'd1;
            end
          end
          default: begin
            state_r <= IDLE;
            cnt_r   <= 3'd0;
          end
        endcase
      end
    end
  end

  assign bus.inst       = inst_r;
  assign bus.inst_valid = inst_valid_r;
  assign bus.adel       = adel_r;
  assign bus.stall_req  = (state_r == BUSY);

endmodule

// File: doc/inst_mem_resp.md
INST_MEM_RESP -- requirements
Module: inst_mem_resp

Interface
REQ-001 SHALL provide parameter DEPTH_LOG2, default 10, meaning log2 of the instruction word count (1024 words).
REQ-002 SHALL provide parameter WAIT_CYCLES, default 1, legal range 0..7, meaning extra wait states per fetch.
REQ-003 SHALL provide port cpu_clk_50M  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL provide port cpu_rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL provide port ice  input  1  fetch request strobe from IF stage.
REQ-006 SHALL provide port iaddr  input  32  fetch byte address, sampled with ice.
REQ-007 SHALL provide port flush  input  1  cancel any pending fetch.
REQ-008 SHALL provide port ld_we  input  1  loader write enable.
REQ-009 SHALL provide port ld_addr  input  DEPTH_LOG2  loader word address.
REQ-010 SHALL provide port ld_data  input  32  loader write data.
REQ-011 SHALL provide port inst  output  32  fetched instruction, registered.
REQ-012 SHALL provide port inst_valid  output  1  one-cycle pulse, inst carries a completed fetch.
REQ-013 SHALL provide port stall_req  output  1  fetch in progress; IF stage holds pc.
REQ-014 SHALL provide port adel  output  1  fetch address error, qualified by inst_valid.

Function
REQ-015 SHALL hold an internal array of 2^DEPTH_LOG2 32-bit words, indexed by iaddr[DEPTH_LOG2+1:2]; upper iaddr bits ignored (address wraps modulo array size).
REQ-016 SHALL implement FSM states IDLE and BUSY plus a wait counter cnt of 3 bits.
REQ-017 In IDLE with ice=1 and flush=0 at edge N: SHALL capture word index and misalign flag (iaddr[1:0]!=0).
REQ-018 If WAIT_CYCLES=0: SHALL register inst and pulse inst_valid in cycle N+1, stay IDLE; back-to-back requests every cycle accepted.
REQ-019 If WAIT_CYCLES>0: SHALL enter BUSY with cnt=WAIT_CYCLES; in BUSY cnt decrements per cycle; on the BUSY edge with cnt==1 register inst, go IDLE; inst_valid pulses in cycle N+1+WAIT_CYCLES.
REQ-020 stall_req SHALL equal (state==BUSY), registered-state-derived, no combinational path from ice.
REQ-021 ice SHALL be ignored while BUSY.
REQ-022 Misaligned fetch: SHALL complete with normal latency, inst=32'h0, adel=1 in the inst_valid cycle; adel=0 otherwise.
REQ-023 inst SHALL hold its last value between completions; inst_valid and adel SHALL be 0 in all non-completion cycles.
REQ-024 flush=1 SHALL force IDLE, cnt=0, suppress the pending inst_valid; flush has priority over a simultaneous ice (request dropped) and over completion in the same cycle.
REQ-025 ld_we=1 SHALL write ld_data to ld_addr at the edge; writes accepted in any state.
REQ-026 Same-edge loader write and fetch read of one word SHALL return the old (pre-write) data.
REQ-027 Memory read for a BUSY fetch SHALL occur at completion edge, so writes landing during the wait are visible.

Reset
REQ-028 cpu_rst=1 SHALL immediately force state=IDLE, cnt=0, inst=32'h0, inst_valid=0, stall_req=0, adel=0.
REQ-029 Reset mid-fetch SHALL abort it; no inst_valid after reset release for that fetch.
REQ-030 Array contents SHALL NOT be reset; loader writes SHALL be ignored while cpu_rst=1.

Verification
REQ-031 WAIT_CYCLES=1: load word 0 = 32'h3C010001, ice=1 iaddr=0 at N -> stall_req=1 in N+1, inst=32'h3C010001 inst_valid=1 stall_req=0 in N+2.
REQ-032 WAIT_CYCLES=0: ice held 1, iaddr 0,4,8 on consecutive edges, words 0xA,0xB,0xC -> inst_valid 1 for three consecutive cycles with 0xA,0xB,0xC, stall_req never 1.
REQ-033 WAIT_CYCLES=3: ice with iaddr=32'h2 -> stall_req 1 for 3 cycles, then inst=0 adel=1 inst_valid=1 for one cycle.
REQ-034 WAIT_CYCLES=3: flush=1 during second BUSY cycle -> stall_req=0 next cycle, no inst_valid, inst keeps prior value; new ice next cycle accepted normally.
REQ-035 DEPTH_LOG2=10: fetch iaddr=32'h1000 -> returns word 0 (wrap); same-edge ld_we to word 0 with 0x55 -> fetch returns old value, refetch returns 0x55.
REQ-036 Assert cpu_rst asynchronously mid-BUSY -> all outputs 0 before next clock edge, no inst_valid after release.
